// File: rtl/crack_controller.sv
`default_nettype none
// ============================================================================
// Module   : crack_controller
// Purpose  : Sequences init/KSA/decrypt engines over a key range and
//            arbitrates the shared S-memory port between them.
// Revision : 1.0
// ============================================================================
module crack_controller #(
    parameter int                   RAM_WIDTH  = 8,
    parameter int                   RAM_LENGTH = 8,
    parameter int                   KEY_WIDTH  = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START  = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_LIMIT  = 'h3FFFFF,
    parameter int                   TIMEOUT    = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               go,
    output logic                               init_start,
    output logic                               ksa_start,
    output logic                               dec_start,
    input  logic                               init_finished,
    input  logic                               ksa_finished,
    input  logic                               dec_finished,
    input  logic                               dec_success,
    input  logic [RAM_LENGTH+RAM_WIDTH:0]      init_sBus,
    input  logic [RAM_LENGTH+RAM_WIDTH:0]      ksa_sBus,
    input  logic [RAM_LENGTH+RAM_WIDTH:0]      dec_sBus,
    output logic [RAM_LENGTH-1:0]              sAddr,
    output logic [RAM_WIDTH-1:0]               sIn,
    output logic                               sWren,
    output logic [KEY_WIDTH-1:0]               key,
    output logic                               busy,
    output logic                               found,
    output logic                               exhausted,
    output logic                               error,
    output logic [7:0]                         stateTap
);

    localparam int               CNT_W      = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT_GO   = 4'd1,
        INIT_WAIT = 4'd2,
        KSA_GO    = 4'd3,
        KSA_WAIT  = 4'd4,
        DEC_GO    = 4'd5,
        DEC_WAIT  = 4'd6,
        NEXT_KEY  = 4'd7,
        FOUND     = 4'd8,
        EXHAUSTED = 4'd9,
        ERROR     = 4'd10
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_load_key;
    logic                   w_inc_key;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_cnt_expired;

    assign w_cnt_expired = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_key   <= KEY_START;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_key) begin
                r_key <= KEY_START;
            end else if (w_inc_key) begin
                r_key <= r_key + KEY_WIDTH'(1);
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_key   = 1'b0;
        w_inc_key    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        init_start   = 1'b0;
        ksa_start    = 1'b0;
        dec_start    = 1'b0;
        busy         = 1'b1;
        found        = 1'b0;
        exhausted    = 1'b0;
        error        = 1'b0;

        case (r_state)
            IDLE, FOUND, EXHAUSTED, ERROR: begin
                busy      = 1'b0;
                found     = (r_state == FOUND);
                exhausted = (r_state == EXHAUSTED);
                error     = (r_state == ERROR);
                if (go) begin
                    w_load_key   = 1'b1;
                    w_next_state = INIT_GO;
                end
            end
            INIT_GO: begin
                init_start   = 1'b1;
                w_cnt_clr    = 1'b1;
                w_next_state = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (init_finished) begin
                    w_next_state = KSA_GO;
                end else if (w_cnt_expired) begin
                    w_next_state = ERROR;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            KSA_GO: begin
                ksa_start    = 1'b1;
                w_cnt_clr    = 1'b1;
                w_next_state = KSA_WAIT;
            end
            KSA_WAIT: begin
                if (ksa_finished) begin
                    w_next_state = DEC_GO;
                end else if (w_cnt_expired) begin
                    w_next_state = ERROR;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DEC_GO: begin
                dec_start    = 1'b1;
                w_cnt_clr    = 1'b1;
                w_next_state = DEC_WAIT;
            end
            DEC_WAIT: begin
                if (dec_finished) begin
                    w_next_state = dec_success ? FOUND : NEXT_KEY;
                end else if (w_cnt_expired) begin
                    w_next_state = ERROR;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            NEXT_KEY: begin
                // Stop on the last key rather than wrapping past it.
                if (r_key == KEY_LIMIT) begin
                    w_next_state = EXHAUSTED;
                end else begin
                    w_inc_key    = 1'b1;
                    w_next_state = INIT_GO;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Only the engine owning the current phase reaches the S port.
    always_comb begin
        sAddr = '0;
        sIn   = '0;
        sWren = 1'b0;
        case (r_state)
            INIT_GO, INIT_WAIT: begin
                sAddr = init_sBus[RAM_LENGTH+RAM_WIDTH:RAM_WIDTH+1];
                sIn   = init_sBus[RAM_WIDTH:1];
                sWren = init_sBus[0];
            end
            KSA_GO, KSA_WAIT: begin
                sAddr = ksa_sBus[RAM_LENGTH+RAM_WIDTH:RAM_WIDTH+1];
                sIn   = ksa_sBus[RAM_WIDTH:1];
                sWren = ksa_sBus[0];
            end
            DEC_GO, DEC_WAIT: begin
                sAddr = dec_sBus[RAM_LENGTH+RAM_WIDTH:RAM_WIDTH+1];
                sIn   = dec_sBus[RAM_WIDTH:1];
                sWren = dec_sBus[0];
            end
            default: begin
                sAddr = '0;
                sIn   = '0;
                sWren = 1'b0;
            end
        endcase
    end

    assign key      = r_key;
    assign stateTap = {4'b0000, r_state};

endmodule
`default_nettype wire

// File: tb/tb_crack_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_crack_controller
// Purpose  : Directed self-checking bench for crack_controller.
// Revision : 1.0
// ============================================================================
module tb_crack_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        init_start, ksa_start, dec_start;
    logic        init_finished = 1'b0, ksa_finished = 1'b0, dec_finished = 1'b0;
    logic        dec_success = 1'b0;
    logic [16:0] init_sBus = '0, ksa_sBus = '0, dec_sBus = '0;
    logic [7:0]  sAddr, sIn;
    logic        sWren;
    logic [23:0] key;
    logic        busy, found, exhausted, error;
    logic [7:0]  stateTap;

    int checks = 0;
    int errors = 0;
    int n_init = 0, n_ksa = 0, n_dec = 0;
    int base_init, base_ksa, base_dec;

    crack_controller #(
        .RAM_WIDTH (8),
        .RAM_LENGTH(8),
        .KEY_WIDTH (24),
        .KEY_START (24'd0),
        .KEY_LIMIT (24'd3),
        .TIMEOUT   (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .init_start   (init_start),
        .ksa_start    (ksa_start),
        .dec_start    (dec_start),
        .init_finished(init_finished),
        .ksa_finished (ksa_finished),
        .dec_finished (dec_finished),
        .dec_success  (dec_success),
        .init_sBus    (init_sBus),
        .ksa_sBus     (ksa_sBus),
        .dec_sBus     (dec_sBus),
        .sAddr        (sAddr),
        .sIn          (sIn),
        .sWren        (sWren),
        .key          (key),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .error        (error),
        .stateTap     (stateTap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_start) n_init++;
        if (ksa_start)  n_ksa++;
        if (dec_start)  n_dec++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic start_of(input int which);
        case (which)
            0:       return init_start;
            1:       return ksa_start;
            default: return dec_start;
        endcase
    endfunction

    task automatic wait_start(input int which);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (start_of(which) === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check($sformatf("start_seen_%0d", which), {31'd0, seen}, 32'd1);
    endtask

    task automatic set_finished(input int which, input logic v);
        case (which)
            0:       init_finished = v;
            1:       ksa_finished  = v;
            default: dec_finished  = v;
        endcase
    endtask

    // Engine model: finishes 5 cycles after its start pulse.
    task automatic phase(input int which, input logic succ);
        wait_start(which);
        repeat (5) @(negedge clk);
        set_finished(which, 1'b1);
        dec_success = succ;
        @(negedge clk);
        set_finished(which, 1'b0);
        dec_success = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic snap();
        base_init = n_init;
        base_ksa  = n_ksa;
        base_dec  = n_dec;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_key", {8'd0, key}, 32'd0);
        check("rst_swren", {31'd0, sWren}, 32'd0);
        check("rst_state", {24'd0, stateTap}, 32'd0);
        check("rst_flags", {29'd0, found, exhausted, error}, 32'd0);
        reset = 1'b1;

        // IDLE: S port parked even with live engine buses
        init_sBus = 17'h1FFFF; ksa_sBus = 17'h1FFFF; dec_sBus = 17'h1FFFF;
        @(negedge clk); #1;
        check("idle_saddr", {24'd0, sAddr}, 32'd0);
        check("idle_sin", {24'd0, sIn}, 32'd0);
        check("idle_swren", {31'd0, sWren}, 32'd0);
        init_sBus = '0; ksa_sBus = '0; dec_sBus = '0;

        // Single key succeeds, with foreign traffic during INIT_WAIT
        snap();
        pulse_go();
        wait_start(0);
        @(negedge clk);
        init_sBus = {8'h12, 8'h34, 1'b0};
        dec_sBus  = {8'hAB, 8'hCD, 1'b1};
        ksa_sBus  = {8'hEF, 8'h01, 1'b1};
        dec_finished = 1'b1; ksa_finished = 1'b1;
        #1;
        check("iw_state", {24'd0, stateTap}, 32'd2);
        check("iw_saddr", {24'd0, sAddr}, 32'h12);
        check("iw_sin", {24'd0, sIn}, 32'h34);
        check("iw_swren0", {31'd0, sWren}, 32'd0);
        @(negedge clk);
        check("iw_stray_ignored", {24'd0, stateTap}, 32'd2);
        dec_finished = 1'b0; ksa_finished = 1'b0;
        init_sBus = {8'h12, 8'h34, 1'b1};
        #1;
        check("iw_swren1", {31'd0, sWren}, 32'd1);
        init_sBus = '0; dec_sBus = '0; ksa_sBus = '0;
        @(negedge clk);
        init_finished = 1'b1;
        @(negedge clk);
        init_finished = 1'b0;
        phase(1, 1'b0);
        phase(2, 1'b1);
        check("a_found", {31'd0, found}, 32'd1);
        check("a_key", {8'd0, key}, 32'd0);
        check("a_busy", {31'd0, busy}, 32'd0);
        check("a_n_init", n_init - base_init, 32'd1);
        check("a_n_ksa", n_ksa - base_ksa, 32'd1);
        check("a_n_dec", n_dec - base_dec, 32'd1);
        repeat (2) @(negedge clk);
        check("a_found_hold", {31'd0, found}, 32'd1);
        check("a_key_hold", {8'd0, key}, 32'd0);

        // Keys 0,1 fail, key 2 succeeds
        snap();
        pulse_go();
        for (int k = 0; k < 3; k++) begin
            phase(0, 1'b0);
            phase(1, 1'b0);
            phase(2, k == 2);
        end
        check("b_found", {31'd0, found}, 32'd1);
        check("b_key", {8'd0, key}, 32'd2);
        check("b_n_init", n_init - base_init, 32'd3);

        // All keys fail: exhausted at the limit
        snap();
        pulse_go();
        for (int k = 0; k < 4; k++) begin
            phase(0, 1'b0);
            phase(1, 1'b0);
            phase(2, 1'b0);
        end
        @(negedge clk);
        check("c_exhausted", {31'd0, exhausted}, 32'd1);
        check("c_found", {31'd0, found}, 32'd0);
        check("c_key", {8'd0, key}, 32'd3);
        check("c_n_dec", n_dec - base_dec, 32'd4);
        check("c_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("c_key_nowrap", {8'd0, key}, 32'd3);

        // KSA engine never finishes: timeout after 64 wait cycles
        pulse_go();
        check("d_cleared", {29'd0, found, exhausted, error}, 32'd0);
        phase(0, 1'b0);
        wait_start(1);
        ksa_sBus = {8'h55, 8'h66, 1'b1};
        @(negedge clk); #1;
        check("d_ksa_swren", {31'd0, sWren}, 32'd1);
        check("d_ksa_saddr", {24'd0, sAddr}, 32'h55);
        repeat (63) @(negedge clk);
        check("d_not_yet", {31'd0, error}, 32'd0);
        check("d_state63", {24'd0, stateTap}, 32'd4);
        @(negedge clk);
        check("d_error", {31'd0, error}, 32'd1);
        check("d_swren", {31'd0, sWren}, 32'd0);
        check("d_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in KSA_WAIT of key 1
        pulse_go();
        phase(0, 1'b0);
        phase(1, 1'b0);
        phase(2, 1'b0);
        phase(0, 1'b0);
        wait_start(1);
        @(negedge clk);
        check("e_key_pre", {8'd0, key}, 32'd1);
        check("e_swren_pre", {31'd0, sWren}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("e_swren", {31'd0, sWren}, 32'd0);
        check("e_busy", {31'd0, busy}, 32'd0);
        check("e_key", {8'd0, key}, 32'd0);
        check("e_state", {24'd0, stateTap}, 32'd0);
        ksa_sBus = '0;
        @(negedge clk);
        reset = 1'b1;
        snap();
        repeat (3) @(negedge clk);
        check("e_stay_idle", {24'd0, stateTap}, 32'd0);
        check("e_no_start", n_init - base_init, 32'd0);
        pulse_go();
        check("e_init_go", {24'd0, stateTap}, 32'd1);
        check("e_init_start", {31'd0, init_start}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crack_controller.md
CRACK_CONTROLLER -- requirements
Module: crack_controller

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8: S-memory data width.
REQ-002 SHALL have parameter RAM_LENGTH, default 8: S-memory address width.
REQ-003 SHALL have parameter KEY_WIDTH, default 24: candidate key width.
REQ-004 SHALL have parameters KEY_START, default 0, and KEY_LIMIT, default 24'h3FFFFF: first and last candidate key, inclusive, with KEY_LIMIT >= KEY_START.
REQ-005 SHALL have parameter TIMEOUT, default 4096: maximum cycles allowed per engine phase.
REQ-006 SHALL provide: clk  in  1  single clock; all flops on posedge.
REQ-007 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL provide: go  in  1  level-sampled search start request.
REQ-009 SHALL provide: init_start, ksa_start, dec_start  out  1 each  one-cycle engine start pulses.
REQ-010 SHALL provide: init_finished, ksa_finished, dec_finished  in  1 each  engine done pulses.
REQ-011 SHALL provide: dec_success  in  1  decrypt result, valid only while dec_finished=1.
REQ-012 SHALL provide: init_sBus, ksa_sBus, dec_sBus  in  RAM_LENGTH+RAM_WIDTH+1 each  {addr, data, wren} S-port request from each engine.
REQ-013 SHALL provide: sAddr / sIn / sWren  out  RAM_LENGTH / RAM_WIDTH / 1  arbitrated S-memory port.
REQ-014 SHALL provide: key  out  KEY_WIDTH  current candidate key.
REQ-015 SHALL provide: busy, found, exhausted, error  out  1 each  status flags.
REQ-016 SHALL provide: stateTap  out  8  current state encoding.

Function
REQ-017 SHALL implement states IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, DEC_GO, DEC_WAIT, NEXT_KEY, FOUND, EXHAUSTED, ERROR.
REQ-018 SHALL, in IDLE/FOUND/EXHAUSTED/ERROR with go=1, load key=KEY_START, clear found/exhausted/error, and enter INIT_GO.
REQ-019 SHALL ignore go in all other states.
REQ-020 SHALL assert init_start, ksa_start, dec_start for exactly one cycle, only in INIT_GO, KSA_GO, DEC_GO respectively; each *_GO lasts one cycle and enters its *_WAIT.
REQ-021 SHALL advance INIT_WAIT->KSA_GO on init_finished=1 and KSA_WAIT->DEC_GO on ksa_finished=1.
REQ-022 SHALL, in DEC_WAIT on dec_finished=1, enter FOUND if dec_success=1, else NEXT_KEY.
REQ-023 SHALL ignore finished pulses from engines not matching the current *_WAIT state.
REQ-024 SHALL, in NEXT_KEY, enter EXHAUSTED with key unchanged if key==KEY_LIMIT; otherwise key<=key+1 and enter INIT_GO. Key never wraps.
REQ-025 SHALL clear a phase cycle counter in every *_GO and increment it each *_WAIT cycle; on reaching TIMEOUT without the expected finished, enter ERROR.
REQ-026 SHALL drive the S port combinationally from init_sBus in INIT_GO/INIT_WAIT, from ksa_sBus in KSA_*, from dec_sBus in DEC_*, and otherwise sAddr=0, sIn=0, sWren=0.
REQ-027 SHALL never pass a non-owning engine's wren to sWren.
REQ-028 SHALL set busy=1 in all states except IDLE, FOUND, EXHAUSTED, ERROR.
REQ-029 SHALL hold found, exhausted, error at 1 while in the matching terminal state, mutually exclusive, and 0 elsewhere.
REQ-030 SHALL keep key stable in FOUND: it is the successful key.

Reset
REQ-031 SHALL, on reset=0 at any time including mid-phase, immediately set state=IDLE, key=KEY_START, counter=0, all *_start=0, sWren=0, busy/found/exhausted/error=0.
REQ-032 SHALL resume only on go after reset deasserts.

Verification
REQ-033 SHALL cover: KEY_START=0, KEY_LIMIT=3, engines finish 5 cycles after start, dec_success=1 -> found=1, key=0, exactly one pulse on each *_start.
REQ-034 SHALL cover: dec_success=0 for keys 0 and 1, then 1 -> found=1, key=2, three init_start pulses.
REQ-035 SHALL cover: dec_success always 0 -> exhausted=1 after key 3, key=3, four dec_start pulses, busy=0.
REQ-036 SHALL cover: TIMEOUT=64, ksa_finished never asserted -> error=1 exactly 64 cycles after entering KSA_WAIT, sWren=0.
REQ-037 SHALL cover: dec_sBus wren=1 and stray dec_finished=1 during INIT_WAIT -> sWren equals init wren only, state unchanged.
REQ-038 SHALL cover: reset=0 mid KSA_WAIT -> same cycle sWren=0, busy=0, key=KEY_START; a new go then runs INIT_GO first.
